// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port mem_controller between three requesters:
//   S - SREC loader (owns the memory exclusively while the machine is in BOOT)
//   D - data-memory pipeline stage
//   F - instruction fetch (read only)
//
// The machine sits in BOOT until the loader raises s_done, then moves to RUN
// permanently (until reset). In RUN, D normally beats F. A small starvation
// counter forces F to win once it has been denied STARVE_LIMIT cycles in a row.
// Every granted read pushes its owner into a MEM_LATENCY-deep shift register
// so that the read data coming back from mem_controller is flagged on the
// right port's rvalid. Reads therefore return in issue order.
//
// Ports:
//   clock, reset_n           clock (posedge) and asynchronous active-low reset
//   s_req/s_address/s_wren/s_wdata, s_done   loader request and boot-done level
//   d_req/d_address/d_wren/d_wdata           data-stage request
//   f_req/f_address                          fetch read request
//   s_gnt/d_gnt/f_gnt        combinational grants for the current cycle
//   s_rvalid/d_rvalid/f_rvalid  read-data-valid per port (from flops)
//   rdata                    mem_data_out passthrough, valid with an rvalid
//   fetch_stall              fetch must hold its PC this cycle
//   running                  high once the machine is in RUN
//   mem_address/mem_wren/mem_data_in  request to mem_controller
//   mem_data_out             read data from mem_controller
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        s_req,
  input  logic [31:0] s_address,
  input  logic        s_wren,
  input  logic [31:0] s_wdata,
  input  logic        s_done,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic        d_wren,
  input  logic [31:0] d_wdata,
  input  logic        f_req,
  input  logic [31:0] f_address,
  output logic        s_gnt,
  output logic        d_gnt,
  output logic        f_gnt,
  output logic        s_rvalid,
  output logic        d_rvalid,
  output logic        f_rvalid,
  output logic [31:0] rdata,
  output logic        fetch_stall,
  output logic        running,
  output logic [31:0] mem_address,
  output logic        mem_wren,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Owner tags carried through the read-return shift register.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_S    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_F    = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e                      state_q, state_d;
  logic [3:0]                  starve_q, starve_d;
  logic [MEM_LATENCY-1:0][1:0] owner_q, owner_d;
  logic [1:0]                  issue_owner;
  logic [1:0]                  ret_owner;
  logic                        starve_hit;

  // State register. BOOT is re-entered only through reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: s_done is only looked at while booting, so a later drop of
  // s_done cannot send the machine back to BOOT.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT && s_done) begin
      state_d = ST_RUN;
    end
  end

  assign starve_hit = (starve_q == LIMIT);

  // Outputs of the FSM: grants, fetch stall and running. Grants are gated by
  // reset_n so that an asserted reset silences the memory bus immediately,
  // even while requesters are still holding their req lines high.
  always_comb begin
    s_gnt       = 1'b0;
    d_gnt       = 1'b0;
    f_gnt       = 1'b0;
    running     = 1'b0;
    fetch_stall = 1'b1;
    if (reset_n) begin
      case (state_q)
        ST_BOOT: begin
          s_gnt = s_req;
        end
        ST_RUN: begin
          running = 1'b1;
          // F wins when alone, or when it has been starved long enough.
          if (f_req && (starve_hit || !d_req)) begin
            f_gnt = 1'b1;
          end else if (d_req) begin
            d_gnt = 1'b1;
          end
          fetch_stall = f_req && d_req && !starve_hit;
        end
        default: begin
          s_gnt = 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts consecutive denied fetch cycles in RUN and
  // saturates at the limit, where it flips priority to F for one grant.
  always_comb begin
    starve_d = 4'd0;
    if (state_q == ST_RUN && f_req && !f_gnt) begin
      starve_d = starve_hit ? starve_q : (starve_q + 4'd1);
    end
  end

  // Memory request mux. Fetch never writes, so wren and write data stay low
  // for an F grant. Writes complete in the grant cycle and tag nothing.
  always_comb begin
    mem_address = 32'd0;
    mem_wren    = 1'b0;
    mem_data_in = 32'd0;
    issue_owner = OWN_NONE;
    if (s_gnt) begin
      mem_address = s_address;
      mem_wren    = s_wren;
      mem_data_in = s_wdata;
      issue_owner = s_wren ? OWN_NONE : OWN_S;
    end else if (d_gnt) begin
      mem_address = d_address;
      mem_wren    = d_wren;
      mem_data_in = d_wdata;
      issue_owner = d_wren ? OWN_NONE : OWN_D;
    end else if (f_gnt) begin
      mem_address = f_address;
      issue_owner = OWN_F;
    end
  end

  // Read-return shift register: stage 0 takes the owner of this cycle's read,
  // the last stage lines up with mem_data_out MEM_LATENCY cycles later.
  always_comb begin
    owner_d[0] = issue_owner;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      owner_d[i] = owner_q[i-1];
    end
  end

  // Starve counter and owner pipeline. Clearing the pipeline on reset drops
  // every in-flight read so nothing returns after reset is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= 4'd0;
      owner_q  <= '0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Only one owner can sit in the last stage, so at most one rvalid is high.
  assign ret_owner = owner_q[MEM_LATENCY-1];
  assign s_rvalid  = (ret_owner == OWN_S);
  assign d_rvalid  = (ret_owner == OWN_D);
  assign f_rvalid  = (ret_owner == OWN_F);
  assign rdata     = mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives directed vectors into mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4)
// with a behavioural memory standing in for mem_controller. A reference model
// tracks BOOT/RUN, the starvation count and a queue of outstanding reads with
// their due cycles, and every cycle the compare process checks the DUT
// against it. Hand-computed literal expectations are queued by the stimulus
// process and checked by the same compare process on the matching cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  localparam int SEL_GNT    = 0;
  localparam int SEL_RVALID = 1;
  localparam int SEL_STALL  = 2;
  localparam int SEL_RUN    = 3;
  localparam int SEL_WREN   = 4;
  localparam int SEL_ADDR   = 5;
  localparam int SEL_RDATA  = 6;
  localparam int SEL_WDATA  = 7;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } ret_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } lit_t;

  logic        clock;
  logic        reset_n;
  logic        s_req, s_wren, s_done;
  logic [31:0] s_address, s_wdata;
  logic        d_req, d_wren;
  logic [31:0] d_address, d_wdata;
  logic        f_req;
  logic [31:0] f_address;
  logic        s_gnt, d_gnt, f_gnt;
  logic        s_rvalid, d_rvalid, f_rvalid;
  logic [31:0] rdata;
  logic        fetch_stall, running;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_wren;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ret_t        ret_q[$];
  lit_t        lit_q[$];
  logic [31:0] mdl_mem[logic [31:0]];
  logic        mdl_running = 1'b0;
  int          mdl_starve  = 0;

  logic [31:0] stub_mem[logic [31:0]];
  logic [31:0] stub_pipe[LAT];

  mem_port_arbiter #(
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .s_req       (s_req),
    .s_address   (s_address),
    .s_wren      (s_wren),
    .s_wdata     (s_wdata),
    .s_done      (s_done),
    .d_req       (d_req),
    .d_address   (d_address),
    .d_wren      (d_wren),
    .d_wdata     (d_wdata),
    .f_req       (f_req),
    .f_address   (f_address),
    .s_gnt       (s_gnt),
    .d_gnt       (d_gnt),
    .f_gnt       (f_gnt),
    .s_rvalid    (s_rvalid),
    .d_rvalid    (d_rvalid),
    .f_rvalid    (f_rvalid),
    .rdata       (rdata),
    .fetch_stall (fetch_stall),
    .running     (running),
    .mem_address (mem_address),
    .mem_wren    (mem_wren),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for mem_controller: read data appears LAT cycles after issue.
  always @(posedge clock) begin
    for (int i = LAT - 1; i > 0; i--) begin
      stub_pipe[i] <= stub_pipe[i-1];
    end
    stub_pipe[0] <= stub_mem.exists(mem_address) ? stub_mem[mem_address] : 32'd0;
    if (mem_wren) begin
      stub_mem[mem_address] = mem_data_in;
    end
  end
  assign mem_data_out = stub_pipe[LAT-1];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] sample_sel(input int sel);
    case (sel)
      SEL_GNT:    return 32'({s_gnt, d_gnt, f_gnt});
      SEL_RVALID: return 32'({s_rvalid, d_rvalid, f_rvalid});
      SEL_STALL:  return 32'(fetch_stall);
      SEL_RUN:    return 32'(running);
      SEL_WREN:   return 32'(mem_wren);
      SEL_ADDR:   return mem_address;
      SEL_RDATA:  return rdata;
      SEL_WDATA:  return mem_data_in;
      default:    return 32'd0;
    endcase
  endfunction

  // Compare process: reference model plus literal expectations, once per cycle.
  initial begin : compare
    logic        eg_s, eg_d, eg_f, e_wren, e_stall;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [2:0]  e_rv;
    int          e_port;
    ret_t        r;
    lit_t        lit;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ret_q.delete();
        mdl_running = 1'b0;
        mdl_starve  = 0;
        check_output("rst_gnt", 32'({s_gnt, d_gnt, f_gnt}), 32'd0);
        check_output("rst_rvalid", 32'({s_rvalid, d_rvalid, f_rvalid}), 32'd0);
        check_output("rst_running", 32'(running), 32'd0);
        check_output("rst_stall", 32'(fetch_stall), 32'd1);
        check_output("rst_mem_addr", mem_address, 32'd0);
        check_output("rst_mem_wren", 32'(mem_wren), 32'd0);
        check_output("rst_mem_wdata", mem_data_in, 32'd0);
      end else begin
        eg_s = !mdl_running && s_req;
        eg_f = mdl_running && f_req && (!d_req || mdl_starve == LIMIT);
        eg_d = mdl_running && d_req && !eg_f;
        e_addr  = 32'd0;
        e_wren  = 1'b0;
        e_wdata = 32'd0;
        if (eg_s) begin
          e_addr = s_address; e_wren = s_wren; e_wdata = s_wdata;
        end else if (eg_d) begin
          e_addr = d_address; e_wren = d_wren; e_wdata = d_wdata;
        end else if (eg_f) begin
          e_addr = f_address;
        end
        e_stall = mdl_running ? (f_req && !eg_f) : 1'b1;
        e_port  = 0;
        e_data  = 32'd0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
          e_port = ret_q[0].port;
          e_data = ret_q[0].data;
          ret_q.delete(0);
        end
        e_rv = {e_port == 1, e_port == 2, e_port == 3};
        check_output("mdl_gnt", 32'({s_gnt, d_gnt, f_gnt}), 32'({eg_s, eg_d, eg_f}));
        check_output("mdl_stall", 32'(fetch_stall), 32'(e_stall));
        check_output("mdl_running", 32'(running), 32'(mdl_running));
        check_output("mdl_mem_addr", mem_address, e_addr);
        check_output("mdl_mem_wren", 32'(mem_wren), 32'(e_wren));
        check_output("mdl_mem_wdata", mem_data_in, e_wdata);
        check_output("mdl_rvalid", 32'({s_rvalid, d_rvalid, f_rvalid}), 32'(e_rv));
        if (e_port != 0) begin
          check_output("mdl_rdata", rdata, e_data);
        end
        // Advance the model to what the coming posedge commits.
        if ((eg_s || eg_d || eg_f) && !e_wren) begin
          r.due  = cyc + LAT;
          r.port = eg_s ? 1 : (eg_d ? 2 : 3);
          r.data = mdl_mem.exists(e_addr) ? mdl_mem[e_addr] : 32'd0;
          ret_q.push_back(r);
        end
        if (e_wren) begin
          mdl_mem[e_addr] = e_wdata;
        end
        if (mdl_running) begin
          if (f_req && !eg_f) begin
            mdl_starve = (mdl_starve < LIMIT) ? mdl_starve + 1 : LIMIT;
          end else begin
            mdl_starve = 0;
          end
        end
        if (!mdl_running && s_done) begin
          mdl_running = 1'b1;
        end
      end
      while (lit_q.size() > 0) begin
        lit = lit_q.pop_front();
        check_output(lit.name, sample_sel(lit.sel), lit.exp);
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_lit(input string name, input int sel, input logic [31:0] exp);
    lit_t l;
    l.name = name;
    l.sel  = sel;
    l.exp  = exp;
    lit_q.push_back(l);
  endtask

  task automatic apply_stimulus(
    input logic sr, input logic [31:0] sa, input logic sw, input logic [31:0] sd, input logic sdone,
    input logic dr, input logic [31:0] da, input logic dw, input logic [31:0] dd,
    input logic fr, input logic [31:0] fa);
    s_req = sr; s_address = sa; s_wren = sw; s_wdata = sd; s_done = sdone;
    d_req = dr; d_address = da; d_wren = dw; d_wdata = dd;
    f_req = fr; f_address = fa;
  endtask

  task automatic apply_idle();
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
  endtask

  initial begin : stimulus
    reset_n = 1'b0;
    apply_idle();
    next_cycle();
    next_cycle();
    expect_lit("reset_stall", SEL_STALL, 32'd1);
    expect_lit("reset_running", SEL_RUN, 32'd0);
    next_cycle();

    // BOOT: loader writes two words while D and F are also requesting.
    reset_n = 1'b1;
    apply_stimulus(1, 32'h8002_0000, 1, 32'h2408_0005, 0, 1, 32'h8002_0100, 0, 32'd0, 1, 32'h8000_0000);
    expect_lit("boot_gnt", SEL_GNT, 32'b100);
    expect_lit("boot_wren", SEL_WREN, 32'd1);
    expect_lit("boot_addr", SEL_ADDR, 32'h8002_0000);
    expect_lit("boot_stall", SEL_STALL, 32'd1);
    expect_lit("boot_running", SEL_RUN, 32'd0);
    next_cycle();
    apply_stimulus(1, 32'h8002_0004, 1, 32'hDEAD_BEEF, 0, 1, 32'h8002_0100, 0, 32'd0, 1, 32'h8000_0000);
    next_cycle();
    apply_stimulus(1, 32'h8002_0000, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    next_cycle();
    apply_idle();
    expect_lit("boot_rd_early", SEL_RVALID, 32'b000);
    next_cycle();
    expect_lit("boot_rd_valid", SEL_RVALID, 32'b100);
    expect_lit("boot_rd_data", SEL_RDATA, 32'h2408_0005);
    next_cycle();

    // Boot exit: last BOOT cycle carries an S read that returns in RUN.
    apply_stimulus(1, 32'h8002_0004, 0, 32'd0, 1, 0, 32'd0, 0, 32'd0, 1, 32'h8002_0000);
    expect_lit("exit_last_boot_gnt", SEL_GNT, 32'b100);
    expect_lit("exit_last_boot_run", SEL_RUN, 32'd0);
    next_cycle();
    apply_stimulus(1, 32'h8002_0000, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 1, 32'h8002_0000);
    expect_lit("exit_run", SEL_RUN, 32'd1);
    expect_lit("exit_f_gnt", SEL_GNT, 32'b001);
    expect_lit("exit_stall", SEL_STALL, 32'd0);
    next_cycle();
    apply_idle();
    expect_lit("exit_s_rvalid", SEL_RVALID, 32'b100);
    expect_lit("exit_s_rdata", SEL_RDATA, 32'hDEAD_BEEF);
    next_cycle();
    expect_lit("exit_f_rvalid", SEL_RVALID, 32'b001);
    expect_lit("exit_f_rdata", SEL_RDATA, 32'h2408_0005);
    next_cycle();

    // D beats F when the starve count is below the limit.
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 1, 32'h8002_0004, 0, 32'd0, 1, 32'h8002_0000);
    expect_lit("dpri_gnt", SEL_GNT, 32'b010);
    expect_lit("dpri_stall", SEL_STALL, 32'd1);
    next_cycle();
    apply_idle();
    next_cycle();
    expect_lit("dpri_rvalid", SEL_RVALID, 32'b010);
    expect_lit("dpri_rdata", SEL_RDATA, 32'hDEAD_BEEF);
    next_cycle();

    // Starvation: D and F held together, F must win every fifth cycle.
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 1, 32'h8002_0000, 0, 32'd0, 1, 32'h8002_0004);
    for (int k = 0; k < 10; k++) begin
      expect_lit($sformatf("starve_gnt_%0d", k), SEL_GNT, (k == 4 || k == 9) ? 32'b001 : 32'b010);
      next_cycle();
    end
    apply_idle();
    next_cycle();
    next_cycle();
    next_cycle();

    // Pipelined mixed reads F, D, F then a D write.
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 1, 32'h8002_0000);
    next_cycle();
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 1, 32'h8002_0004, 0, 32'd0, 0, 32'd0);
    next_cycle();
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 1, 32'h8002_0004);
    expect_lit("pipe_rv0", SEL_RVALID, 32'b001);
    expect_lit("pipe_rd0", SEL_RDATA, 32'h2408_0005);
    next_cycle();
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 1, 32'h8002_0008, 1, 32'h0BAD_F00D, 0, 32'd0);
    expect_lit("pipe_rv1", SEL_RVALID, 32'b010);
    expect_lit("pipe_rd1", SEL_RDATA, 32'hDEAD_BEEF);
    expect_lit("pipe_wr_wren", SEL_WREN, 32'd1);
    expect_lit("pipe_wr_data", SEL_WDATA, 32'h0BAD_F00D);
    next_cycle();
    apply_idle();
    expect_lit("pipe_rv2", SEL_RVALID, 32'b001);
    expect_lit("pipe_rd2", SEL_RDATA, 32'hDEAD_BEEF);
    next_cycle();
    expect_lit("pipe_wr_no_rv", SEL_RVALID, 32'b000);
    next_cycle();

    // Async reset between a granted read and its return.
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 1, 32'h8002_0008, 0, 32'd0, 1, 32'h8002_0000);
    expect_lit("arst_issue_gnt", SEL_GNT, 32'b010);
    next_cycle();
    s_req = 1'b1;
    #2;
    reset_n = 1'b0;
    expect_lit("arst_gnt", SEL_GNT, 32'b000);
    expect_lit("arst_stall", SEL_STALL, 32'd1);
    expect_lit("arst_addr", SEL_ADDR, 32'd0);
    next_cycle();
    expect_lit("arst_no_return", SEL_RVALID, 32'b000);
    next_cycle();
    apply_idle();
    reset_n = 1'b1;
    expect_lit("arst_post_rv", SEL_RVALID, 32'b000);
    expect_lit("arst_post_run", SEL_RUN, 32'd0);
    next_cycle();
    apply_stimulus(0, 32'd0, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 1, 32'h8002_0000);
    expect_lit("arst_boot_gnt", SEL_GNT, 32'b000);
    expect_lit("arst_boot_stall", SEL_STALL, 32'd1);
    next_cycle();
    apply_idle();
    expect_lit("arst_post_rv2", SEL_RVALID, 32'b000);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port mem_controller between three requesters: SREC loader (port S), data-memory stage (port D) and fetch (port F).
- Holds the machine in BOOT until the loader signals done; the loader has exclusive access during BOOT.
- In RUN it grants one requester per cycle and routes read data back to the owner after a fixed latency.
- Generates the fetch stall. Sits between the pipeline stages and mem_controller.

Parameters:
- MEM_LATENCY, 1, cycles from granted read issue to valid mem_data_out (1..4).
- STARVE_LIMIT, 4, consecutive denied F-request cycles before F is forced to win (1..15).

Ports:
- clock  in  1  system clock, posedge
- reset_n  in  1  asynchronous, active-low reset
- s_req / s_address[0:31] / s_wren / s_wdata[0:31]  in  1/32/1/32  SREC loader request
- s_done  in  1  loader finished; level, sampled on posedge
- d_req / d_address[0:31] / d_wren / d_wdata[0:31]  in  1/32/1/32  data-memory request
- f_req / f_address[0:31]  in  1/32  fetch read request; fetch never writes
- s_gnt, d_gnt, f_gnt  out  1 each  combinational grant, this cycle
- s_rvalid, d_rvalid, f_rvalid  out  1 each  registered read-data-valid, one per port
- rdata[0:31]  out  32  mem_data_out passthrough, meaningful only with an rvalid
- fetch_stall  out  1  high when F must hold its PC
- running  out  1  high in RUN state
- mem_address[0:31] / mem_wren / mem_data_in[0:31]  out  32/1/32  to mem_controller
- mem_data_out[0:31]  in  32  from mem_controller

Behaviour:
- Reset (async, reset_n=0):
  - state=BOOT; starve counter=0; owner pipeline cleared.
  - All gnt and rvalid = 0; running=0; fetch_stall=1.
  - mem_wren=0; mem_address=0; mem_data_in=0.
  - Reset mid-transfer drops every in-flight read; no rvalid is emitted for it.
- BOOT state:
  - s_gnt = s_req; d_gnt = f_gnt = 0; fetch_stall = 1.
  - On a posedge with s_done=1: next state RUN. This takes effect from the next cycle; the current cycle's S grant still issues.
  - BOOT->RUN is one-way; s_done falling afterwards is ignored until reset.
- RUN state:
  - s_gnt = 0.
  - Priority is D > F, unless the starve counter equals STARVE_LIMIT; then F > D for that cycle.
  - Starve counter:
    - increments (saturating at STARVE_LIMIT) on each cycle with f_req=1 and f_gnt=0;
    - clears on f_gnt=1 or f_req=0.
  - fetch_stall = f_req & ~f_gnt.
  - Simultaneous D and F with counter < LIMIT: D wins, F stalls.
- Memory mux (combinational):
  - Granted port drives mem_address, mem_wren and mem_data_in (F forces wren=0, wdata=0).
  - No grant: mem_wren=0, mem_address=0, mem_data_in=0.
- Read return:
  - A granted read (wren=0) pushes the owner ID into a MEM_LATENCY-deep shift register.
  - That port's rvalid is high for exactly 1 cycle, MEM_LATENCY cycles after the grant cycle.
  - Writes push "none": no rvalid, done in the grant cycle.
  - A new grant is allowed every cycle; back-to-back reads from mixed ports return in issue order.
  - At most one rvalid is high per cycle.
- rvalid is not gated by the current grant. A read issued in the last BOOT cycle still returns on s_rvalid in RUN.

Test Plan:
- Reset then BOOT:
  - Stimulus: reset_n low 2 cycles, then release; assert d_req=1, f_req=1, s_req=1 with s_address=0x8002_0000, s_wren=1, s_wdata=0x2408_0005.
  - Required: only s_gnt=1; mem_wren=1; fetch_stall=1; running=0.
  - Readback of 0x8002_0000 via S returns 0x2408_0005 with s_rvalid exactly MEM_LATENCY cycles later.
- Boot exit:
  - Stimulus: s_done=1 at cycle N.
  - Required: running=1 from N+1; f_req alone gives f_gnt=1, fetch_stall=0; f_rvalid pulses at N+1+MEM_LATENCY.
- D priority:
  - Stimulus: d_req=1 (read 0x8002_0004) and f_req=1 in the same cycle.
  - Required: d_gnt=1, f_gnt=0, fetch_stall=1; d_rvalid only, with rdata = stored word.
- Starvation:
  - Stimulus: d_req and f_req held high continuously with STARVE_LIMIT=4.
  - Required: D granted 4 cycles, F granted on the 5th, then D for 4 again; pattern repeats.
- Pipelined mixed reads (MEM_LATENCY=2):
  - Stimulus: grants F, D, F on consecutive cycles.
  - Required: f_rvalid, d_rvalid, f_rvalid on consecutive cycles starting 2 cycles later; D writes produce no rvalid.
- Async reset mid-read:
  - Stimulus: reset_n low between a granted read and its return.
  - Required: all outputs at reset values immediately; no rvalid after release; state=BOOT.
